// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shared multiply/divide engine producing HI/LO for MULT, MULTU, DIV, DIVU.
// Optional build macro MULDIV_EARLY_EXIT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FIX = 2'b10, DONE = 2'b11} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;  // sign of product (mult) or quotient (div)
  logic               neg_hi_q, neg_hi_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0]   qr_q, qr_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               div0_q, div0_d;
  logic               busy_q, done_q;

  logic               a_neg, b_neg, last_step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     trial;

  function automatic logic [WIDTH-1:0] cneg(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = cneg(a_neg, a);
  assign b_mag = cneg(b_neg, b);
  // Restoring-division trial: shift next dividend bit into the partial remainder, subtract divisor.
  assign trial = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]} - {1'b0, sh_q[WIDTH-1:0]};

`ifdef MULDIV_EARLY_EXIT_EN
  assign last_step = (cnt_q == LAST) || (!is_div_q && (qr_q[WIDTH-1:1] == '0));
`else
  assign last_step = (cnt_q == LAST);
`endif

  // Next-state and datapath step logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    qr_d     = qr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div0_d   = div0_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = op[1];
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          cnt_d    = '0;
          acc_d    = '0;
          if (op[1]) begin
            sh_d = {{WIDTH{1'b0}}, b_mag};
            qr_d = a_mag;
          end else begin
            sh_d = {{WIDTH{1'b0}}, a_mag};
            qr_d = b_mag;
          end
          if (op[1] && (b == '0)) begin
            div0_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          qr_d  = {qr_q[WIDTH-2:0], ~trial[WIDTH]};
          acc_d = {{WIDTH{1'b0}},
                   trial[WIDTH] ? {acc_q[WIDTH-2:0], qr_q[WIDTH-1]} : trial[WIDTH-1:0]};
        end else begin
          if (qr_q[0]) begin
            acc_d = acc_q + sh_q;
          end else begin
            acc_d = acc_q;
          end
          sh_d = sh_q << 1;
          qr_d = qr_q >> 1;
        end
        if (last_step) begin
          state_d = FIX;
        end else begin
          state_d = RUN;
        end
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = cneg(neg_lo_q, qr_q);
          hi_d = cneg(neg_hi_q, acc_q[WIDTH-1:0]);
        end else begin
          {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
        end
        div0_d  = 1'b0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_q    <= '0;
      sh_q     <= '0;
      qr_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      qr_q     <= qr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div0_q   <= div0_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div0_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops against an arithmetic model,
// and hand-written sequences for ignored start pulses, divide-by-zero and mid-operation reset.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (o == 2'b00) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    return 64'(sx * sy);
  endfunction

  // Returns {remainder, quotient}; divisor must be nonzero.
  function automatic logic [63:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    if (o == 2'b10) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] y);
    logic [31:0] m;
    int h;
    if (o[1]) return (y == 32'd0) ? 1 : W + 2;
    if (!EE) return W + 2;
    m = (o == 2'b00 && y[31]) ? -y : y;
    h = 0;
    for (int i = 0; i < 32; i++) if (m[i]) h = i;
    return h + 3;
  endfunction

  // Issues one operation and waits for done; lat is cycles from the start edge (-1 on timeout).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] rh, output logic [31:0] rl,
                        output logic rdz, output logic rbusy);
    lat = -1; rh = 'x; rl = 'x; rdz = 1'bx; rbusy = 1'bx;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    for (int j = 0; j < 80; j++) begin
      if (done) begin
        lat = j + 1; rh = hi; rl = lo; rdz = div_zero; rbusy = busy;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t        vt[13];
  int          lat, ndone, dj;
  logic [31:0] rh, rl, m_hi, m_lo, eh, el, x, y;
  logic        rdz, rbusy, ed;
  logic [1:0]  o;
  logic [63:0] r;

  initial begin
    vt[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    vt[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, EE ? 5 : 34};
    vt[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vt[3]  = '{2'b11, 32'd100,      32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1};
    vt[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vt[5]  = '{2'b01, 32'd5,        32'd1,        32'h00000000, 32'h00000005, 1'b0, EE ? 3 : 34};
    vt[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
    vt[7]  = '{2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, EE ? 3 : 34};
    vt[8]  = '{2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1};
    vt[9]  = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 34};
    vt[10] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    vt[11] = '{2'b11, 32'd5,        32'd7,        32'h00000005, 32'h00000000, 1'b0, 34};
    vt[12] = '{2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, EE ? 3 : 34};

    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.div_zero", 64'(div_zero), 64'd0);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, lat, rh, rl, rdz, rbusy);
      chk($sformatf("vec%0d.hi", i), 64'(rh), 64'(vt[i].hi));
      chk($sformatf("vec%0d.lo", i), 64'(rl), 64'(vt[i].lo));
      chk($sformatf("vec%0d.div_zero", i), 64'(rdz), 64'(vt[i].dz));
      chk($sformatf("vec%0d.latency", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("vec%0d.busy_at_done", i), 64'(rbusy), 64'd1);
      m_hi = vt[i].hi;
      m_lo = vt[i].lo;
    end

    for (int n = 0; n < 150; n++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       x = $urandom;
        1:       x = $urandom_range(0, 255);
        2:       x = 32'h80000000;
        default: x = -32'($urandom_range(1, 300));
      endcase
      case ($urandom_range(0, 4))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 40);
        2:       y = -32'($urandom_range(1, 40));
        default: y = $urandom;
      endcase
      if (o[1] && y == 32'd0) begin
        eh = m_hi; el = m_lo; ed = 1'b1;
      end else begin
        r = o[1] ? ref_div(o, x, y) : ref_mul(o, x, y);
        eh = r[63:32]; el = r[31:0]; ed = 1'b0;
      end
      run_op(o, x, y, lat, rh, rl, rdz, rbusy);
      chk($sformatf("rnd%0d.hi", n), 64'(rh), 64'(eh));
      chk($sformatf("rnd%0d.lo", n), 64'(rl), 64'(el));
      chk($sformatf("rnd%0d.div_zero", n), 64'(rdz), 64'(ed));
      chk($sformatf("rnd%0d.latency", n), 64'(lat), 64'(ref_lat(o, y)));
      m_hi = eh;
      m_lo = el;
    end

    // Start pulses during RUN, FIX and the done cycle must all be ignored.
    r = ref_mul(2'b00, 32'd3, 32'h80000000);
    @(negedge clk);
    op = 2'b00; a = 32'd3; b = 32'h80000000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0; dj = -1; rh = 'x; rl = 'x;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      start = (j == 5 || j == 33 || j == 34);
      op = 2'($urandom); a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (dj < 0) begin
          dj = j; rh = hi; rl = lo;
        end
      end
    end
    start = 1'b0;
    chk("ignore.done_count", 64'(ndone), 64'd1);
    chk("ignore.latency", 64'(dj + 1), 64'd34);
    chk("ignore.hi", 64'(rh), 64'(r[63:32]));
    chk("ignore.lo", 64'(rl), 64'(r[31:0]));
    chk("ignore.idle_busy", 64'(busy), 64'd0);
    chk("ignore.hold_hi", 64'(hi), 64'(r[63:32]));
    m_hi = r[63:32];
    m_lo = r[31:0];

    run_op(2'b11, 32'd100, 32'd0, lat, rh, rl, rdz, rbusy);
    chk("divu0.latency", 64'(lat), 64'd1);
    chk("divu0.div_zero", 64'(rdz), 64'd1);
    chk("divu0.hi", 64'(rh), 64'(m_hi));
    chk("divu0.lo", 64'(rl), 64'(m_lo));
    chk("divu0.flag_held", 64'(div_zero), 64'd1);

    // Reset mid-multiply discards the operation and clears outputs.
    @(negedge clk);
    op = 2'b00; a = 32'h01234567; b = 32'h89ABCDEF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset.busy", 64'(busy), 64'd0);
    chk("midreset.done", 64'(done), 64'd0);
    chk("midreset.hi", 64'(hi), 64'd0);
    chk("midreset.lo", 64'(lo), 64'd0);
    chk("midreset.div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("midreset.no_done", 64'(ndone), 64'd0);
    chk("midreset.lo_after", 64'(lo), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
